// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage between inst_mem and decode.
//
// The stage keeps the PC and drives it straight out as the inst_mem read
// address. Each returning word is captured, together with its PC, in a
// 2-entry FIFO that decode drains over a valid/ready handshake.
//
// At most one read is in flight at a time. A read is issued only when the
// FIFO is guaranteed to have room for its word, so backpressure never drops
// a word. A redirect loads a new PC and flushes the in-flight read and all
// buffered words.
//
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched and perf_stall.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   imem_addr_r     read address to inst_mem (the PC register)
//   imem_data       inst_mem read data, one cycle after the address
//   redirect_valid  load redirect_pc and flush all fetched words
//   redirect_pc     redirect target word address
//   if_valid        FIFO head valid to decode
//   if_ready        decode accepts the head this cycle
//   if_instr        head instruction (0 when empty)
//   if_pc           head word address (0 when empty)
//   perf_fetched    [FETCH_PERF_CNT_EN] count of handshake cycles
//   perf_stall      [FETCH_PERF_CNT_EN] count of cycles held by decode
module inst_fetch #(
    parameter int                ADDR_W   = 10,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr_r,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    logic [ADDR_W-1:0] pc;
    logic              req_v;
    logic [ADDR_W-1:0] req_pc;

    logic [DATA_W-1:0] fifo_instr [2];
    logic [ADDR_W-1:0] fifo_pc    [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credit;

    assign imem_addr_r = pc;

    // A redirect hides the head, so no handshake can complete on that cycle.
    assign if_valid = (count != 2'd0) && !redirect_valid;
    assign if_instr = (count != 2'd0) ? fifo_instr[rd_ptr] : '0;
    assign if_pc    = (count != 2'd0) ? fifo_pc[rd_ptr]    : '0;

    assign pop  = if_valid && if_ready;
    // The returning word belongs to the old path when a redirect is present.
    assign push = req_v && !redirect_valid;

    // Occupancy after this edge, counting the in-flight word as already
    // stored. Issuing only below 2 means every issued word has a free slot.
    // count >= pop always holds, so the subtraction cannot underflow.
    assign credit = {1'b0, count} + {2'b0, req_v} - {2'b0, pop};
    assign issue  = !redirect_valid && (credit < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            req_v         <= 1'b0;
            req_pc        <= '0;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            req_v  <= 1'b0;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_data;
                fifo_pc[wr_ptr]    <= req_pc;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            req_v <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + 1'b1;  // wraps at 2^ADDR_W
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if ((count != 2'd0) && !if_ready && !redirect_valid) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. A behavioural 1-cycle synchronous-read
// memory feeds the DUT; each task drives one scenario and checks inline.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  imem_addr_r;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mem [1024];

    inst_fetch #(.ADDR_W(10), .DATA_W(32), .RESET_PC(10'd0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr_r    (imem_addr_r),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr_r];

    // Memory image: the three test-plan words, everything else tagged by address.
    function automatic logic [31:0] word(input int p);
        logic [9:0] a;
        a = p[9:0];
        case (a)
            10'd0:   return 32'hAAAA_BBBB;
            10'd1:   return 32'h1234_5678;
            10'd2:   return 32'hDEAD_BEEF;
            default: return {16'hC0DE, 6'b0, a};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset and release with if_ready as given; returns just after release.
    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = rdy;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", if_valid); else n_pass++;
        n_total++; if (if_instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", if_instr); else n_pass++;
        n_total++; if (if_pc !== 10'h0) $display("FAIL reset_pc got=%h exp=0", if_pc); else n_pass++;
        n_total++; if (imem_addr_r !== 10'h0) $display("FAIL reset_addr got=%h exp=0", imem_addr_r); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        step();
        n_total++; if (if_valid !== 1'b0) $display("FAIL lat_edge1_valid got=%0b exp=0", if_valid); else n_pass++;
        n_total++; if (imem_addr_r !== 10'd1) $display("FAIL lat_edge1_addr got=%h exp=1", imem_addr_r); else n_pass++;
        step();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== k[9:0] || if_instr !== word(k))
                $display("FAIL stream_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, k[9:0], word(k));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (if_valid !== 1'b1 || if_instr !== 32'hAAAA_BBBB || if_pc !== 10'd0)
                $display("FAIL bp_hold_%0d got v=%0b instr=%h pc=%h exp v=1 instr=aaaabbbb pc=0",
                         k, if_valid, if_instr, if_pc);
            else n_pass++;
            step();
        end
        n_total++; if (imem_addr_r !== 10'd2) $display("FAIL bp_addr_stall got=%h exp=2", imem_addr_r); else n_pass++;
        if_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== k[9:0] || if_instr !== word(k))
                $display("FAIL bp_release_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, k[9:0], word(k));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_redirect_wrap();
        do_reset(1'b0);
        step(); step(); step(); step();   // FIFO full (pcs 0,1)
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FE;
        #1;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rd_cycle_valid got=%0b exp=0", if_valid); else n_pass++;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        #1;
        n_total++; if (if_valid !== 1'b0 || imem_addr_r !== 10'h3FE)
            $display("FAIL rd_after1 got v=%0b addr=%h exp v=0 addr=3fe", if_valid, imem_addr_r); else n_pass++;
        step();
        n_total++; if (if_valid !== 1'b0) $display("FAIL rd_after2_valid got=%0b exp=0", if_valid); else n_pass++;
        step();
        for (int k = 0; k < 3; k++) begin
            int p;
            p = (10'h3FE + k) % 1024;
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== p[9:0] || if_instr !== word(p))
                $display("FAIL rd_wrap_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, p[9:0], word(p));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] f0;
`endif
        do_reset(1'b1);
        step(); step(); step();          // streaming, head valid
`ifdef FETCH_PERF_CNT_EN
        f0 = perf_fetched;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 10'h010;
        #1;
        n_total++; if (if_valid !== 1'b0) $display("FAIL b2b_valid_first got=%0b exp=0", if_valid); else n_pass++;
        step();
        redirect_pc = 10'h020;
        #1;
        n_total++; if (if_valid !== 1'b0 || imem_addr_r !== 10'h010)
            $display("FAIL b2b_second got v=%0b addr=%h exp v=0 addr=010", if_valid, imem_addr_r); else n_pass++;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        n_total++; if (perf_fetched !== f0) $display("FAIL b2b_perf got=%0d exp=%0d", perf_fetched, f0); else n_pass++;
`endif
        step();
        step();
        n_total++; if (if_valid !== 1'b1 || if_pc !== 10'h020 || if_instr !== word(32))
            $display("FAIL b2b_first_pc got v=%0b pc=%h instr=%h exp v=1 pc=020 instr=%h",
                     if_valid, if_pc, if_instr, word(32)); else n_pass++;
        step();
        n_total++; if (if_valid !== 1'b1 || if_pc !== 10'h021)
            $display("FAIL b2b_second_pc got v=%0b pc=%h exp v=1 pc=021", if_valid, if_pc); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        step(); step(); step();          // buffered words present
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 10'h0 || imem_addr_r !== 10'h0)
            $display("FAIL async_rst got v=%0b instr=%h pc=%h addr=%h exp all 0",
                     if_valid, if_instr, if_pc, imem_addr_r); else n_pass++;
        step();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        step();
        n_total++; if (if_valid !== 1'b0) $display("FAIL async_restart_lat got=%0b exp=0", if_valid); else n_pass++;
        step();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== k[9:0] || if_instr !== word(k))
                $display("FAIL async_restart_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         k, if_valid, if_pc, if_instr, k[9:0], word(k));
            else n_pass++;
            step();
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset(1'b0);
        step(); step();                  // head valid from here
        step(); step(); step(); step();  // 4 stall cycles
        if_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        if_ready = 1'b0;
        #1;
        n_total++; if (perf_fetched !== 32'd10) $display("FAIL perf_fetched got=%0d exp=10", perf_fetched); else n_pass++;
        n_total++; if (perf_stall !== 32'd4) $display("FAIL perf_stall got=%0d exp=4", perf_stall); else n_pass++;
        force dut.perf_fetched_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fetched_q;
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        n_total++; if (perf_fetched !== 32'd0) $display("FAIL perf_wrap got=%h exp=0", perf_fetched); else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = word(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wrap();
        test_back_to_back();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage, directly upstream of decode and the consumer of inst_mem's read port.
- Holds the PC and drives inst_mem's read address, then captures the returned 32-bit word.
- Delivers {instruction, pc} pairs to decode over a valid/ready handshake.
- Supports downstream backpressure via a 2-entry buffer, and redirect (branch/jump) with flush of wrong-path words.

Parameters:
ADDR_W, 10, word-address width; matches inst_mem addr_r
DATA_W, 32, instruction width
RESET_PC, 0, word address fetched first after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr_r  output  ADDR_W  read address to inst_mem; equals PC register
imem_data  input  DATA_W  inst_mem data_out; word for address presented one cycle earlier (1-cycle synchronous read)
redirect_valid  input  1  load new PC, flush all in-flight/buffered words
redirect_pc  input  ADDR_W  redirect target word address
if_valid  output  1  buffer head valid to decode
if_ready  input  1  decode accepts head this cycle
if_instr  output  DATA_W  head instruction
if_pc  output  ADDR_W  word address of head instruction

Behaviour:
- Reset (async, immediate, no clock needed): pc=RESET_PC, req_v=0, buffer count=0, if_valid=0, if_instr=0, if_pc=0, imem_addr_r=RESET_PC.
- State: pc, req_v/req_pc (one in-flight read), 2-entry FIFO {instr,pc}, count 0..2.
- Pop = if_valid && if_ready. Push = req_v, at the edge after the request: stores {imem_data, req_pc}.
- Issue rule: issue when count + req_v - pop < 2. On issue, req_v<=1, req_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, 0x3FF -> 0x000). When not issuing, req_v<=0 and pc holds.
- The credit rule guarantees no push into a full FIFO. Push+pop in the same cycle leaves count unchanged.
- Latency: first request on the 1st edge after rst_n rises; if_valid=1 after the 2nd edge. Steady state with if_ready=1 is 1 instruction/cycle, pcs consecutive.
- Outputs: if_valid = (count!=0) && !redirect_valid. if_instr/if_pc = FIFO head when count!=0, else 0.
- Redirect (priority over everything):
  - At the edge: count<=0, req_v<=0 (the returning word is discarded), pc<=redirect_pc.
  - During the redirect cycle: no issue; if_valid forced 0, so no handshake can complete.
  - The next cycle issues redirect_pc; its word is at decode 2 edges after the redirect edge.
- Back-to-back redirects: the last one wins, and every flush rule applies each cycle.
- Reset mid-operation: all state discarded. Fetch restarts at RESET_PC with the same latency as initial reset.
- No instruction is ever duplicated, dropped (except by redirect), or reordered.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_fetched (32-bit): counts pop cycles.
  - perf_stall (32-bit): counts cycles with count!=0 && !if_ready && !redirect_valid.
- Both reset to 0, wrap at 2^32, and are unaffected by redirect.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Preload mem 0:AAAA_BBBB, 1:1234_5678, 2:DEAD_BEEF; release reset with if_ready=1 -> if_valid rises after the 2nd edge; (instr,pc) = (AAAABBBB,0), (12345678,1), (DEADBEEF,2) on consecutive cycles.
- Hold if_ready=0 for 5 cycles after the first valid -> if_valid=1 and if_instr=AAAABBBB stable; imem_addr_r stops advancing at 2. Release -> pcs 0,1,2,3 delivered once each, no gaps.
- Redirect to 0x3FE with FIFO full -> if_valid=0 in the redirect cycle; next delivered pcs 0x3FE, 0x3FF, 0x000 (wrap); no pre-redirect pc ever appears.
- Redirect asserted with if_valid && if_ready in the same cycle -> if_valid reads 0, no handshake counted; two redirects back-to-back (0x010 then 0x020) -> first delivered pc 0x020.
- Assert rst_n=0 between clock edges mid-stream -> if_valid, if_instr, if_pc go 0 immediately and imem_addr_r=RESET_PC; after release, stream restarts at pc 0.
- With FETCH_PERF_CNT_EN defined: 10 pops and 4 stall cycles -> perf_fetched=10, perf_stall=4; preload 0xFFFF_FFFF via force -> wraps to 0 on the next pop.
